// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one barrel shifter (SLL/SRL/SRA).
// The arbiter is round-robin, and each side has a valid/ready handshake.
// The result is registered and held on a tagged response channel until the
// consumer takes it.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/ready              handshake for requester N (0: ALU, 1: expand/imm)
//   reqN_op                       00 SLL, 01 SRL, 10 SRA, 11 reserved
//   reqN_a, reqN_b                value to shift, shift-amount operand (low SHAMT_W bits)
//   rsp_valid/ready               response handshake
//   rsp_data, rsp_id, rsp_err     result, issuing requester, reserved-op flag
module shift_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_id,
   output logic             rsp_err
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t              state;
   logic                ptr;        // 0: req0 has priority, 1: req1 has priority
   logic                can_accept;
   logic                grant0;
   logic                grant1;
   logic                accept;
   logic [1:0]          sel_op;
   logic [WIDTH-1:0]    sel_a;
   logic [SHAMT_W-1:0]  shamt;
   logic [WIDTH-1:0]    result;
   logic                unused_b_bits;

   // The shifter only uses the low bits of b. The upper bits are ignored.
   assign unused_b_bits = ^{req0_b[WIDTH-1:SHAMT_W], req1_b[WIDTH-1:SHAMT_W]};

   // Grant and accept window, the operand mux, and the shifter.
   always_comb begin
      can_accept = 1'b0;
      grant0     = 1'b0;
      grant1     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      sel_op     = 2'b00;
      sel_a      = '0;
      shamt      = '0;
      result     = '0;

      can_accept = (state == IDLE) | ((state == HOLD) & rsp_ready);
      grant0     = req0_valid & (~req1_valid | ~ptr);
      grant1     = req1_valid & (~req0_valid |  ptr);
      // Readys are suppressed while reset is asserted, so a reset cycle never handshakes.
      req0_ready = ~rst & can_accept & grant0;
      req1_ready = ~rst & can_accept & grant1;
      accept     = req0_ready | req1_ready;

      if (grant1) begin
         sel_op = req1_op;
         sel_a  = req1_a;
         shamt  = req1_b[SHAMT_W-1:0];
      end else begin
         sel_op = req0_op;
         sel_a  = req0_a;
         shamt  = req0_b[SHAMT_W-1:0];
      end

      case (sel_op)
         2'b00:   result = sel_a << shamt;
         2'b01:   result = sel_a >> shamt;
         2'b10:   result = $unsigned($signed(sel_a) >>> shamt);
         default: result = '0;
      endcase
   end

   // Response FSM, priority pointer, and held result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            // A new accept overwrites any result that drains in the same cycle.
            state     <= HOLD;
            rsp_valid <= 1'b1;
            rsp_data  <= result;
            rsp_id    <= grant1;
            rsp_err   <= (sel_op == 2'b11);
            ptr       <= ~grant1;
         end else if ((state == HOLD) && rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter.
// A cycle model predicts the readys and rsp_valid. Every accepted operation
// pushes its expected response into a queue. The held response is compared
// against the queue head, and the head is popped on each response handshake.
module tb_shift_arbiter;

   typedef struct packed {
      logic [31:0] d;
      logic        id;
      logic        err;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [1:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_id, rsp_err;

   int   total = 0;
   int   bad   = 0;
   logic m_hold = 1'b0;
   logic m_ptr  = 1'b0;
   logic rnd    = 1'b0;
   rsp_t q[$];

   shift_arbiter #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_id(rsp_id), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference shifter: shifts one bit position at a time.
   function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] r;
      r = a;
      if (op == 2'b11) return 32'h0;
      for (int i = 0; i < int'(b[4:0]); i++) begin
         case (op)
            2'b00:   r = {r[30:0], 1'b0};
            2'b01:   r = {1'b0, r[31:1]};
            default: r = {r[31], r[31:1]};
         endcase
      end
      return r;
   endfunction

   task automatic drive(input logic v0, input logic [1:0] o0, input logic [31:0] a0,
                        input logic [31:0] b0, input logic v1, input logic [1:0] o1,
                        input logic [31:0] a1, input logic [31:0] b1, input logic rr);
      req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
      rsp_ready  = rr;
   endtask

   // Checks one cycle against the model, then advances one clock.
   task automatic tick();
      logic e0, e1, can, acc, gid;
      rsp_t r;
      e0 = 1'b0; e1 = 1'b0;
      #1;
      if (!rst) begin
         can = !m_hold || rsp_ready;
         e0  = can && req0_valid && (!req1_valid || !m_ptr);
         e1  = can && req1_valid && (!req0_valid ||  m_ptr);
      end
      check("rdy0", 32'(req0_ready), 32'(e0));
      check("rdy1", 32'(req1_ready), 32'(e1));
      check("rsp_valid", 32'(rsp_valid), 32'(m_hold));
      if (m_hold) begin
         if (q.size() == 0) check("sb_empty", 32'(q.size()), 32'd1);
         else begin
            check("rsp_data", rsp_data, q[0].d);
            check("rsp_id", 32'(rsp_id), 32'(q[0].id));
            check("rsp_err", 32'(rsp_err), 32'(q[0].err));
         end
      end
      acc = e0 || e1;
      gid = e1;
      r.d   = gid ? ref_shift(req1_op, req1_a, req1_b) : ref_shift(req0_op, req0_a, req0_b);
      r.id  = gid;
      r.err = gid ? (req1_op == 2'b11) : (req0_op == 2'b11);
      @(posedge clk);
      if (rst) begin
         m_hold = 1'b0; m_ptr = 1'b0; q.delete();
      end else begin
         if (m_hold && rsp_ready && q.size() > 0) void'(q.pop_front());
         if (acc) begin
            q.push_back(r);
            m_ptr = !gid;
         end
         m_hold = acc || (m_hold && !rsp_ready);
      end
      @(negedge clk);
      if (rnd) begin
         // New payloads appear only once the previous one was taken.
         if (!req0_valid || (acc && !gid)) begin
            req0_valid = 1'($urandom_range(0, 1));
            req0_op = 2'($urandom_range(0, 3)); req0_a = $urandom; req0_b = $urandom;
         end
         if (!req1_valid || (acc && gid)) begin
            req1_valid = 1'($urandom_range(0, 1));
            req1_op = 2'($urandom_range(0, 3)); req1_a = $urandom; req1_b = $urandom;
         end
         rsp_ready = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(1, 2'b00, 32'h1, 32'h1, 1, 2'b00, 32'h1, 32'h1, 1);
      @(posedge clk); @(negedge clk);
      tick();                                   // readys must stay low under reset
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_data", rsp_data, 32'h0);
      check("rst_id", 32'(rsp_id), 32'd0);
      check("rst_err", 32'(rsp_err), 32'd0);

      // Basic SLL with the maximum shift amount.
      drive(1, 2'b00, 32'h0000_0001, 32'h0000_001F, 0, 0, 0, 0, 1);
      tick();
      check("sll_data", rsp_data, 32'h8000_0000);
      check("sll_id", 32'(rsp_id), 32'd0);

      // SRA and SRL with shift-amount masking on req1.
      drive(0, 0, 0, 0, 1, 2'b10, 32'h8000_0000, 32'hFFFF_FFE4, 1);
      tick();
      check("sra_data", rsp_data, 32'hF800_0000);
      check("sra_id", 32'(rsp_id), 32'd1);
      drive(0, 0, 0, 0, 1, 2'b01, 32'h8000_0000, 32'hFFFF_FFE4, 1);
      tick();
      check("srl_data", rsp_data, 32'h0800_0000);
      drive(0, 0, 0, 0, 1, 2'b10, 32'h1234_5678, 32'h0, 1);
      tick();
      check("shamt0", rsp_data, 32'h1234_5678);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();

      // Round-robin from reset under continuous contention.
      rst = 1'b1; tick(); rst = 1'b0;
      drive(1, 2'b00, 32'h1234_5678, 32'd3, 1, 2'b10, 32'h8765_4321, 32'd7, 1);
      for (int i = 0; i < 6; i++) begin
         #1 check("rr_grant", 32'(req1_ready), 32'(i % 2));
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick(); tick();

      // Backpressure: the held result stays stable and req0 waits.
      drive(1, 2'b01, 32'hF0F0_F0F0, 32'd4, 0, 0, 0, 0, 1);
      tick();
      drive(1, 2'b00, 32'h0000_0003, 32'd1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_data", rsp_data, 32'h0F0F_0F0F);
      end
      rsp_ready = 1'b1;
      #1 check("bp_accept", 32'(req0_ready), 32'd1);
      tick();
      check("bp_result", rsp_data, 32'h0000_0006);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();

      // Reserved op consumes a grant, and the next contended grant goes to req1.
      drive(1, 2'b11, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 1);
      tick();
      check("rsv_data", rsp_data, 32'h0);
      check("rsv_err", 32'(rsp_err), 32'd1);
      drive(1, 2'b00, 32'h5, 32'd1, 1, 2'b01, 32'h5, 32'd1, 1);
      #1 check("rsv_next", 32'(req1_ready), 32'd1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick(); tick();

      // Reset while a result is held.
      drive(0, 0, 0, 0, 1, 2'b00, 32'hABCD_0001, 32'd8, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      check("pre_rst_valid", 32'(rsp_valid), 32'd1);
      rst = 1'b1;
      drive(1, 2'b00, 32'h1, 32'h2, 1, 2'b00, 32'h1, 32'h3, 0);
      tick();
      rst = 1'b0;
      check("mid_rst_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_data", rsp_data, 32'h0);
      rsp_ready = 1'b1;
      #1 check("post_rst_grant0", 32'(req0_ready), 32'd1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();

      // Random traffic with random backpressure.
      rnd = 1'b1;
      for (int i = 0; i < 300; i++) tick();
      rnd = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit shifter datapath between two requesters: req0 is the execute-stage ALU shift path, req1 is the compressed-instruction expansion/immediate path.
- Handles SLL, SRL and SRA.
- Arbitration is round-robin; each side uses a valid/ready handshake.
- The result is registered and held on a single tagged response channel until the consumer takes it.

Parameters:
- WIDTH, 32, data width of operands and result.
- SHAMT_W, 5, number of low bits of operand B used as shift amount.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req0_valid  input  1  requester 0 presents an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
- req0_a  input  WIDTH  value to shift.
- req0_b  input  WIDTH  shift-amount operand; only bits [SHAMT_W-1:0] used.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as req0_*, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result this cycle.
- rsp_data  output  WIDTH  shift result.
- rsp_id  output  1  requester that issued the result (0/1).
- rsp_err  output  1  operation used reserved op 11.

Behaviour:
- Clocking and reset:
  - Single clock domain, clk only.
  - rst is synchronous and active-high, sampled on the rising edge of clk.
  - Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, state=IDLE, priority pointer=req0.
- FSM states: IDLE (no result held) and HOLD (result held, rsp_valid=1).
- Accept window:
  - `can_accept = (state==IDLE) | (state==HOLD & rsp_ready)`.
  - This allows back-to-back throughput of one op per cycle.
- Grant:
  - Computed combinationally from the valids and the priority pointer.
  - Only one valid: that requester wins.
  - Both valid: the pointer's requester wins.
  - `reqN_ready = can_accept & grantN`. At most one ready is high in any cycle, and ready never rises without the matching valid.
- On accept (rising edge):
  - rsp_data is loaded with the result.
  - rsp_id is loaded with the granted index.
  - rsp_err is loaded with (op==11).
  - State moves to HOLD.
  - The pointer moves to the other requester.
- Latency: the result is visible one cycle after the accept handshake.
- HOLD with rsp_ready=1 and no accept: rsp_valid=0 next cycle, state moves to IDLE; rsp_data/rsp_id/rsp_err keep their old values.
- HOLD with rsp_ready=0:
  - All outputs stay stable and both readys stay low.
  - Requesters must keep valid and payload stable until ready.
- Arithmetic (shamt = b[SHAMT_W-1:0]; upper bits of b are ignored):
  - SLL: `a << shamt`.
  - SRL: logical right shift, zero fill.
  - SRA: arithmetic right shift, sign of a[WIDTH-1] replicated.
  - shamt=0 returns a unchanged.
  - op 11: rsp_data=0, rsp_err=1, still consumes a grant and advances the pointer.
- Pointer: changes only on an accept; idle cycles do not move it.
- Reset mid-operation: a held result is discarded with no response issued; no readys are asserted during the reset cycle.
- Simultaneous events: in the same cycle as a response handshake, a new accept overwrites the held result and state stays HOLD.

Test Plan:
- Basic SLL: reset, then req0 with op=00, a=0x0000_0001, b=0x0000_001F. Expect req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_data=0x8000_0000, rsp_id=0, rsp_err=0.
- Shift-amount masking and SRA: req1 with op=10, a=0x8000_0000, b=0xFFFF_FFE4 (shamt=4) -> rsp_data=0xF800_0000, rsp_id=1. Same operands with op=01 -> rsp_data=0x0800_0000.
- Round-robin under contention: both valid continuously, rsp_ready=1. Expect grants 0,1,0,1 from reset, one accept per cycle, and rsp_id sequence 0,1,0,1 delayed one cycle.
- Backpressure:
  - Hold rsp_ready=0 for 3 cycles with req0 pending.
  - Expect rsp_valid/rsp_data stable and req0_ready=0 throughout.
  - Raise rsp_ready: the same cycle accepts the pending req0, and the next cycle shows its result.
- Reserved op: req0 with op=11, a=0xFFFF_FFFF -> rsp_data=0, rsp_err=1. The next contended grant goes to req1.
- Reset mid-HOLD:
  - With rsp_valid=1 and rsp_ready=0, assert rst for one cycle.
  - Expect rsp_valid=0, rsp_data=0 and both readys low during the reset cycle.
  - After reset with both valid, req0 is granted first.
